// File: rtl/sipo_rx.sv
// Serial-in, parallel-out receiver: assembles LSB-first WIDTH-bit words from a
// bit-enabled serial stream and hands them off through a one-word valid/ready holding register.
module sipo_rx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             shift,
    input  logic             clr,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             busy
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic [0:0]       state, state_nxt;

    logic             take;
    logic             complete;
    logic             accept;
    logic             load;
    logic             drop;
    logic [WIDTH-1:0] word;

    // clr wins over shift, so a flush cycle never samples sin or completes a word
    assign take     = shift & ~clr;
    assign complete = take & (cnt == LAST);
    assign word     = {sin, sr[WIDTH-1:1]};

    assign out_valid = (state == ST_FULL);
    assign accept    = out_valid & out_ready;
    assign load      = complete & (~out_valid | out_ready);
    assign drop      = complete & out_valid & ~out_ready;
    assign busy      = (cnt != '0);

    // Shift register and bit counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (clr) begin
            sr  <= '0;
            cnt <= '0;
        end else if (take) begin
            sr  <= word;
            cnt <= complete ? '0 : cnt + CW'(1);
        end
    end

    // Holding register state: FULL stays FULL when an accept and a completion coincide
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (complete)            state_nxt = ST_FULL;
            ST_FULL:  if (accept && !complete) state_nxt = ST_EMPTY;
            default:                           state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_EMPTY;
            out_data <= '0;
        end else begin
            state <= state_nxt;
            if (load) out_data <= word;
        end
    end

    // Sticky drop flag; only a flush or reset clears it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      overrun <= 1'b0;
        else if (clr)  overrun <= 1'b0;
        else if (drop) overrun <= 1'b1;
    end

endmodule

// File: tb/tb_sipo_rx.sv
// Directed table-driven bench for sipo_rx (WIDTH = 4) plus a hand-written
// asynchronous mid-word reset sequence.
module tb_sipo_rx;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         sin, shift, clr, out_ready;
    logic [W-1:0] out_data;
    logic         out_valid, overrun, busy;

    int n_vec = 0;
    int n_err = 0;

    sipo_rx #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .shift     (shift),
        .clr       (clr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         sin;
        logic         shift;
        logic         ready;
        logic         clr;
        logic [W-1:0] data;
        logic         valid;
        logic         ovr;
        logic         busy;
        string        name;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic s, input logic sh, input logic rd, input logic cl,
                       input logic [W-1:0] d, input logic v, input logic o, input logic b,
                       input string nm);
        vec_t e;
        e.sin = s; e.shift = sh; e.ready = rd; e.clr = cl;
        e.data = d; e.valid = v; e.ovr = o; e.busy = b; e.name = nm;
        tbl.push_back(e);
    endtask

    task automatic check(input string nm, input logic [W-1:0] d, input logic v,
                         input logic o, input logic b);
        n_vec++;
        if (out_data !== d || out_valid !== v || overrun !== o || busy !== b) begin
            n_err++;
            $display("FAIL %s: got data=%h valid=%b ovr=%b busy=%b, want data=%h valid=%b ovr=%b busy=%b",
                     nm, out_data, out_valid, overrun, busy, d, v, o, b);
        end
    endtask

    task automatic drive(input logic s, input logic sh, input logic rd, input logic cl);
        sin = s; shift = sh; out_ready = rd; clr = cl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

    initial begin
        //  sin sh rd cl  data  v  o  b
        // Basic word 1,1,0,1 -> B, then accept
        add(1, 1, 0, 0, 4'h0, 0, 0, 1, "basic b0");
        add(1, 1, 0, 0, 4'h0, 0, 0, 1, "basic b1");
        add(0, 1, 0, 0, 4'h0, 0, 0, 1, "basic b2");
        add(1, 1, 0, 0, 4'hB, 1, 0, 0, "basic done");
        add(0, 0, 0, 0, 4'hB, 1, 0, 0, "basic hold");
        add(0, 0, 1, 0, 4'hB, 0, 0, 0, "basic accept");
        add(0, 0, 1, 0, 4'hB, 0, 0, 0, "ready while empty");
        // Gapped 0,1,1,1 -> E
        add(0, 1, 0, 0, 4'hB, 0, 0, 1, "gap b0");
        add(1, 0, 0, 0, 4'hB, 0, 0, 1, "gap idle0");
        add(1, 1, 0, 0, 4'hB, 0, 0, 1, "gap b1");
        add(0, 0, 0, 0, 4'hB, 0, 0, 1, "gap idle1");
        add(0, 0, 0, 0, 4'hB, 0, 0, 1, "gap idle1b");
        add(1, 1, 0, 0, 4'hB, 0, 0, 1, "gap b2");
        add(0, 0, 0, 0, 4'hB, 0, 0, 1, "gap idle2");
        add(1, 1, 0, 0, 4'hE, 1, 0, 0, "gap done");
        add(0, 0, 1, 0, 4'hE, 0, 0, 0, "gap accept");
        // Back-to-back 1,0,0,0,0,1,0,1 with ready held -> 1 then A
        add(1, 1, 1, 0, 4'hE, 0, 0, 1, "b2b b0");
        add(0, 1, 1, 0, 4'hE, 0, 0, 1, "b2b b1");
        add(0, 1, 1, 0, 4'hE, 0, 0, 1, "b2b b2");
        add(0, 1, 1, 0, 4'h1, 1, 0, 0, "b2b word1");
        add(0, 1, 1, 0, 4'h1, 0, 0, 1, "b2b b4");
        add(1, 1, 1, 0, 4'h1, 0, 0, 1, "b2b b5");
        add(0, 1, 1, 0, 4'h1, 0, 0, 1, "b2b b6");
        add(1, 1, 1, 0, 4'hA, 1, 0, 0, "b2b word2");
        add(0, 0, 1, 0, 4'hA, 0, 0, 0, "b2b drain");
        // Overrun: 3 held, C dropped, accept, clr
        add(1, 1, 0, 0, 4'hA, 0, 0, 1, "ovr a0");
        add(1, 1, 0, 0, 4'hA, 0, 0, 1, "ovr a1");
        add(0, 1, 0, 0, 4'hA, 0, 0, 1, "ovr a2");
        add(0, 1, 0, 0, 4'h3, 1, 0, 0, "ovr word3");
        add(0, 1, 0, 0, 4'h3, 1, 0, 1, "ovr c0");
        add(0, 1, 0, 0, 4'h3, 1, 0, 1, "ovr c1");
        add(1, 1, 0, 0, 4'h3, 1, 0, 1, "ovr c2");
        add(1, 1, 0, 0, 4'h3, 1, 1, 0, "ovr drop");
        add(0, 0, 1, 0, 4'h3, 0, 1, 0, "ovr accept sticky");
        add(0, 0, 0, 0, 4'h3, 0, 1, 0, "ovr sticky idle");
        add(0, 0, 0, 1, 4'h3, 0, 0, 0, "ovr clr");
        // Simultaneous accept and completion: 5 held, 9 arrives with ready
        add(1, 1, 0, 0, 4'h3, 0, 0, 1, "sim a0");
        add(0, 1, 0, 0, 4'h3, 0, 0, 1, "sim a1");
        add(1, 1, 0, 0, 4'h3, 0, 0, 1, "sim a2");
        add(0, 1, 0, 0, 4'h5, 1, 0, 0, "sim word5");
        add(1, 1, 0, 0, 4'h5, 1, 0, 1, "sim b0");
        add(0, 1, 0, 0, 4'h5, 1, 0, 1, "sim b1");
        add(0, 1, 0, 0, 4'h5, 1, 0, 1, "sim b2");
        add(1, 1, 1, 0, 4'h9, 1, 0, 0, "sim accept+complete");
        add(0, 0, 1, 0, 4'h9, 0, 0, 0, "sim drain");
        // Flush mid-word: 2 bits, clr with shift, then 6; held word survives clr
        add(1, 1, 0, 0, 4'h9, 0, 0, 1, "flush p0");
        add(1, 1, 0, 0, 4'h9, 0, 0, 1, "flush p1");
        add(1, 1, 0, 1, 4'h9, 0, 0, 0, "flush clr+shift");
        add(0, 1, 0, 0, 4'h9, 0, 0, 1, "flush b0");
        add(1, 1, 0, 0, 4'h9, 0, 0, 1, "flush b1");
        add(1, 1, 0, 0, 4'h9, 0, 0, 1, "flush b2");
        add(0, 1, 0, 0, 4'h6, 1, 0, 0, "flush word6");
        add(0, 0, 0, 1, 4'h6, 1, 0, 0, "clr keeps held word");
        add(0, 0, 1, 0, 4'h6, 0, 0, 0, "flush accept");

        rst = 1'b0; sin = 1'b0; shift = 1'b0; clr = 1'b0; out_ready = 1'b0;
        #12;
        check("reset state", 4'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].sin, tbl[i].shift, tbl[i].ready, tbl[i].clr);
            check(tbl[i].name, tbl[i].data, tbl[i].valid, tbl[i].ovr, tbl[i].busy);
        end

        // Async reset mid-word while a word is held and overrun is set
        drive(1, 1, 0, 0); drive(0, 1, 0, 0); drive(1, 1, 0, 0);
        drive(1, 1, 0, 0);                                   // completes D, held
        drive(0, 1, 0, 0); drive(1, 1, 0, 0); drive(0, 1, 0, 0);
        drive(1, 1, 0, 0);                                   // dropped -> overrun
        drive(1, 1, 0, 0); drive(1, 1, 0, 0); drive(1, 1, 0, 0);
        check("pre-reset", 4'hD, 1'b1, 1'b1, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("async reset immediate", 4'h0, 1'b0, 1'b0, 1'b0);
        shift = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        drive(0, 0, 0, 0);
        check("no pulse after release", 4'h0, 1'b0, 1'b0, 1'b0);
        drive(0, 1, 0, 0); drive(0, 1, 0, 0); drive(1, 1, 0, 0);
        check("post-reset partial", 4'h0, 1'b0, 1'b0, 1'b1);
        drive(1, 1, 0, 0);
        check("post-reset word C", 4'hC, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sipo_rx.md
# sipo_rx

Serial-in, parallel-out receiver: the receive end of the LSB-first serial stream our parallel-in/serial-out shifter produces. It samples one bit per enabled clock, assembles WIDTH-bit words and presents each completed word on a parallel output with a valid/ready handshake. A one-word holding register decouples the shifter from the consumer, and an overrun flag reports words dropped because the consumer was not ready.

## Interface
- WIDTH, 4: word size in bits; legal range WIDTH >= 2.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-low reset; clears all state immediately on assertion.
- sin  input  1  serial data bit; sampled only when shift = 1.
- shift  input  1  bit-enable; when 1, sin is sampled on this rising edge.
- clr  input  1  synchronous flush: discards the partial word and clears overrun.
- out_data  output  WIDTH  last completed word, bit 0 = first bit received.
- out_valid  output  1  holding register contains a word not yet accepted.
- out_ready  input  1  consumer accepts out_data when out_valid & out_ready.
- overrun  output  1  sticky; a completed word was dropped.
- busy  output  1  partial word in progress (bit count != 0).

## Operation
- Shift register sr[WIDTH-1:0] and bit counter cnt (width $clog2(WIDTH)).
- LSB-first assembly. On shift: sr <= {sin, sr[WIDTH-1:1]}, so after WIDTH samples the first bit sits in bit 0.
- cnt increments on each shift. At cnt == WIDTH-1 with shift, the word completes:
  - the complete word is {sin, sr[WIDTH-1:1]};
  - cnt wraps to 0.
- The output side has two states:
  - EMPTY (out_valid = 0): a completed word loads out_data; the state moves to FULL.
  - FULL (out_valid = 1): on out_ready the word is accepted.
    - If no word completes in the same cycle, the state returns to EMPTY.
    - If a word completes in the same cycle, out_data loads the new word and the state stays FULL; this is not an overrun.
  - FULL, !out_ready, word completes: the new word is dropped, out_data keeps the old word, overrun <= 1.
- out_data holds its value while EMPTY; it changes only when a word completes into it.
- clr:
  - sets cnt <= 0, sr <= 0 and overrun <= 0;
  - has priority over shift in the same cycle; that cycle's sin is discarded and no word completes;
  - does not affect out_data, out_valid or the handshake, so a held word survives clr.
- busy = (cnt != 0); it is combinational from cnt.

## Timing
- Reset values: out_data = 0, out_valid = 0, overrun = 0, busy = 0; also cnt = 0 and sr = 0.
- Reset takes effect asynchronously on the falling edge of rst. Reset during a partial word discards it, with no output pulse after release.
- Latency: out_valid is 1 after the same rising edge that samples the WIDTH-th bit, i.e. 0 cycles after the last bit.
- The next word's first bit may be sampled in the cycle right after completion, giving continuous streaming at 1 bit/clk.
- Gaps with shift = 0 freeze cnt and sr indefinitely. There is no timeout.
- Handshake: out_valid, once set, stays 1 until accepted. out_data is stable while out_valid = 1 && !out_ready.
- out_ready while out_valid = 0 is ignored.
- Overrun: overrun goes to 1 on the edge of the dropped completion and stays 1 until clr or reset.

## Test plan
- Basic word (WIDTH = 4): shift = 1 with sin = 1,1,0,1 over 4 cycles, out_ready = 0.
  - After the 4th edge: out_data = 4'hB, out_valid = 1, busy = 0.
  - Then out_ready = 1 for one cycle: out_valid = 0 after that edge, and out_data still reads 4'hB.
- Gapped input: bits 0,1,1,1 with shift = 0 idle cycles between each bit.
  - out_data = 4'hE only after the 4th enabled edge.
  - busy = 1 between bits.
- Back-to-back with continuous out_ready = 1: stream 8 bits 1,0,0,0,0,1,0,1.
  - Words 4'h1 then 4'hA.
  - out_valid is high for the single cycle after each completion.
  - overrun stays 0.
- Overrun: complete 4'h3, hold out_ready = 0, then complete 4'hC.
  - out_data stays 4'h3 and overrun = 1.
  - Accept the word, then pulse clr: overrun = 0.
- Simultaneous accept and complete: 4'h5 held, then out_ready = 1 on the edge that completes 4'h9.
  - out_data = 4'h9, out_valid stays 1, overrun = 0.
- Flush and reset mid-word:
  - Send 2 bits, pulse clr together with shift, then send 4'h6: out_data = 4'h6.
  - Separately, assert rst asynchronously after 3 bits: all outputs 0 immediately, and the next full 4 bits yield the correct word.
